vga_frame_sequencer: RTL
========================

Name: vga_frame_sequencer

Overview:
- Generates VGA raster timing (DE, HSync, VSync, pixel coordinates) that drives the pattern generators in the video path.
- Schedules which of several pattern generators is shown.
- The pattern select advances on frame boundaries only: automatically every FRAMES_PER_PAT frames, or on a user "next" request.
- Sits between the pixel clock domain root and the pattern generators/colour mux.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, active level of o_HSync (0 = active-low)
VS_POL, 0, active level of o_VSync
NUM_PAT, 4, number of patterns; must be >=1 and <=2^PAT_W
PAT_W, 2, width of o_PatSel
FRAMES_PER_PAT, 60, frames each pattern is shown in auto mode; must be >=1

Ports:
i_Clk  in  1  pixel clock; the only clock
i_Rst_n  in  1  asynchronous active-low reset
i_Next  in  1  synchronous request to advance pattern; rising-edge detected
i_Hold  in  1  1 = suppress automatic advance
o_HSync  out  1  horizontal sync, polarity HS_POL
o_VSync  out  1  vertical sync, polarity VS_POL
o_DE  out  1  data enable, high in active area
o_X  out  10  horizontal pixel counter
o_Y  out  10  vertical line counter
o_FrameStart  out  1  one-cycle pulse at pixel (0,0)
o_PatSel  out  PAT_W  selected pattern index

Behaviour:
- Internal counters:
  - h runs 0..H_TOTAL-1 (H_TOTAL = sum of H_* = 800) and wraps to 0.
  - v increments when h wraps; v runs 0..V_TOTAL-1 (525) and wraps to 0.
- Horizontal decode:
  - Active area: h < H_ACTIVE.
  - Sync active: H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751 by default).
- Vertical decode: same scheme (sync lines 490..491 by default).
- DE = h active AND v active.
- All outputs are registered with 1-cycle latency from the counters. o_X, o_Y, o_DE, o_HSync, o_VSync and o_FrameStart are mutually aligned: in any cycle they describe the same (h,v).
- o_X/o_Y count through blanking; they are not clamped.
- Reset (async assert, sync deassert by design of the reset tree):
  - h = v = 0; o_X = o_Y = 0; o_DE = 0; o_FrameStart = 0.
  - o_HSync = !HS_POL; o_VSync = !VS_POL.
  - o_PatSel = 0; frame counter = 0; next-pending = 0.
  - First edge after release: outputs show (0,0) with DE = 1 and o_FrameStart = 1.
- Frame end: the cycle where h = H_TOTAL-1 and v = V_TOTAL-1.
- i_Next handling:
  - Rising edge of i_Next (compared with its previous-cycle value) sets next-pending.
  - Further edges while pending are absorbed; no queuing.
- At frame end:
  - advance = next-pending OR (!i_Hold AND frame counter == FRAMES_PER_PAT-1).
  - If advance: o_PatSel <= (o_PatSel == NUM_PAT-1) ? 0 : o_PatSel+1; frame counter <= 0; next-pending <= 0.
  - Else: frame counter += 1 if !i_Hold, else held.
  - o_PatSel changes in the same edge that makes o_FrameStart = 1; it never changes mid-frame.
- Simultaneous events:
  - i_Next edge in the frame-end cycle counts for this boundary.
  - Manual and auto advance coinciding give a single increment.
- i_Hold while a request is pending: the pending request is still honoured.
- NUM_PAT = 1: o_PatSel stays 0; the frame counter still clears on advance.
- Reset mid-frame: immediate return to reset values; raster restarts at (0,0).

Test Plan:
1. Reset held, then released -> during reset o_HSync = 1, o_VSync = 1, o_DE = 0, o_PatSel = 0; first cycle after release o_X = 0, o_Y = 0, o_DE = 1, o_FrameStart = 1.
2. Line timing, defaults -> per line o_DE high exactly 640 consecutive cycles; o_HSync low for 96 cycles while o_X = 656..751; line period 800 cycles.
3. Frame timing -> o_VSync low while o_Y = 490..491; o_FrameStart period exactly 420000 cycles; o_DE never high for o_Y >= 480.
4. Auto advance with FRAMES_PER_PAT=2, NUM_PAT=3, i_Hold=0 -> o_PatSel sequence 0,0,1,1,2,2,0 per frame; each change coincides with o_FrameStart. With i_Hold=1 -> o_PatSel constant over 10 frames.
5. i_Next pulse at o_Y = 100 with i_Hold=1 -> o_PatSel unchanged until next o_FrameStart, then +1. Three pulses in one frame -> +1 only.
6. i_Next edge exactly in the frame-end cycle while the auto counter also expires -> o_PatSel increments by exactly 1. Async reset asserted at o_X = 300, o_Y = 200 -> outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/vga_frame_sequencer.sv
// VGA raster timing generator with frame-synchronous pattern scheduling.
// Every output is registered one cycle behind the h/v counters, so all of them describe the same pixel.
module vga_frame_sequencer #(
  parameter int H_ACTIVE       = 640,
  parameter int H_FP           = 16,
  parameter int H_SYNC         = 96,
  parameter int H_BP           = 48,
  parameter int V_ACTIVE       = 480,
  parameter int V_FP           = 10,
  parameter int V_SYNC         = 2,
  parameter int V_BP           = 33,
  parameter int HS_POL         = 0,
  parameter int VS_POL         = 0,
  parameter int NUM_PAT        = 4,
  parameter int PAT_W          = 2,
  parameter int FRAMES_PER_PAT = 60
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_Next,
  input  logic             i_Hold,
  output logic             o_HSync,
  output logic             o_VSync,
  output logic             o_DE,
  output logic [9:0]       o_X,
  output logic [9:0]       o_Y,
  output logic             o_FrameStart,
  output logic [PAT_W-1:0] o_PatSel
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FC_W    = (FRAMES_PER_PAT > 1) ? $clog2(FRAMES_PER_PAT) : 1;

  localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FRAMES_PER_PAT - 1);
  localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(NUM_PAT - 1);
  localparam logic             HS_ON    = (HS_POL != 0);
  localparam logic             VS_ON    = (VS_POL != 0);

  logic [9:0]       h_q, h_d, v_q, v_d;
  logic [9:0]       x_q, y_q;
  logic             de_q, hs_q, vs_q, fs_q, frame_end_q;
  logic             next_prev_q, pend_q, pend_d;
  logic [FC_W-1:0]  fc_q, fc_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             h_act, v_act, h_sync, v_sync, next_edge, advance;

  assign h_act  = (h_q < H_ACT_END);
  assign v_act  = (v_q < V_ACT_END);
  assign h_sync = (h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END);
  assign v_sync = (v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END);

  // frame_end_q is aligned with the outputs: it marks the cycle that shows the last pixel,
  // so the pattern update lands on the same edge that raises o_FrameStart.
  assign next_edge = i_Next & ~next_prev_q;
  assign advance   = frame_end_q & (pend_q | next_edge | (~i_Hold & (fc_q == FC_LAST)));

  always_comb begin
    h_d    = h_q + 10'd1;
    v_d    = v_q;
    pend_d = pend_q | next_edge;
    fc_d   = fc_q;
    pat_d  = pat_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end
    if (advance) begin
      pat_d  = (pat_q == PAT_LAST) ? '0 : pat_q + 1'b1;
      fc_d   = '0;
      pend_d = 1'b0;
    end else if (frame_end_q && !i_Hold) begin
      fc_d = fc_q + 1'b1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      h_q         <= '0;
      v_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      de_q        <= 1'b0;
      hs_q        <= ~HS_ON;
      vs_q        <= ~VS_ON;
      fs_q        <= 1'b0;
      frame_end_q <= 1'b0;
      next_prev_q <= 1'b0;
      pend_q      <= 1'b0;
      fc_q        <= '0;
      pat_q       <= '0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      x_q         <= h_q;
      y_q         <= v_q;
      de_q        <= h_act & v_act;
      hs_q        <= h_sync ? HS_ON : ~HS_ON;
      vs_q        <= v_sync ? VS_ON : ~VS_ON;
      fs_q        <= (h_q == '0) && (v_q == '0);
      frame_end_q <= (h_q == H_LAST) && (v_q == V_LAST);
      next_prev_q <= i_Next;
      pend_q      <= pend_d;
      fc_q        <= fc_d;
      pat_q       <= pat_d;
    end
  end

  assign o_X          = x_q;
  assign o_Y          = y_q;
  assign o_DE         = de_q;
  assign o_HSync      = hs_q;
  assign o_VSync      = vs_q;
  assign o_FrameStart = fs_q;
  assign o_PatSel     = pat_q;

endmodule
